// File: rtl/semaforo_pkg.sv
// Shared types and constants for the semaforo intersection controller.
// Helper functions map a phase to its timing-table entry and to each head's lamp pattern.
package semaforo_pkg;

    typedef enum logic [2:0] {
        StInit = 3'd0,
        StNsG  = 3'd1,
        StNsY  = 3'd2,
        StClr  = 3'd3,
        StEwG  = 3'd4,
        StEwY  = 3'd5,
        StPed  = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        CfgGreen  = 2'd0,
        CfgYellow = 2'd1,
        CfgAllRed = 2'd2,
        CfgWalk   = 2'd3
    } cfg_sel_e;

    typedef enum logic {
        DirNs = 1'b0,
        DirEw = 1'b1
    } dir_e;

    // Lamp patterns are {R,Y,G}
    localparam logic [2:0] LightRed    = 3'b100;
    localparam logic [2:0] LightYellow = 3'b010;
    localparam logic [2:0] LightGreen  = 3'b001;

    localparam int unsigned DefGreen  = 4;
    localparam int unsigned DefYellow = 2;
    localparam int unsigned DefAllRed = 1;
    localparam int unsigned DefWalk   = 3;

    // A programmed zero still gives the phase one full second.
    function automatic logic [3:0] load_secs(input logic [3:0] v);
        logic [3:0] r;
        r = (v == 4'd0) ? 4'd1 : v;
        return r;
    endfunction

    function automatic cfg_sel_e secs_sel(input phase_e p);
        cfg_sel_e s;
        case (p)
            StNsG, StEwG: s = CfgGreen;
            StNsY, StEwY: s = CfgYellow;
            StPed:        s = CfgWalk;
            default:      s = CfgAllRed;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] ns_head(input phase_e p);
        logic [2:0] l;
        case (p)
            StNsG:   l = LightGreen;
            StNsY:   l = LightYellow;
            default: l = LightRed;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] ew_head(input phase_e p);
        logic [2:0] l;
        case (p)
            StEwG:   l = LightGreen;
            StEwY:   l = LightYellow;
            default: l = LightRed;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_sched_tick_gen.sv
// One-second tick prescaler: counts 0..CLK_HZ-1 and pulses tick on the last count.
// restart zeroes the count so a new phase always starts on a fresh second.
module tick_gen #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CntW-1:0] cnt_q;

    assign tick = (cnt_q == CntW'(CLK_HZ - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/semaforo_sched.sv
// Actuated two-approach intersection controller with a pedestrian phase and a
// run-time programmable seconds table; lamp outputs are registered from the next phase.
module semaforo_sched
    import semaforo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned DEF_GREEN  = DefGreen,
    parameter int unsigned DEF_YELLOW = DefYellow,
    parameter int unsigned DEF_ALLRED = DefAllRed,
    parameter int unsigned DEF_WALK   = DefWalk
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_btn,
    input  logic       cfg_load,
    input  logic [1:0] cfg_sel,
    input  logic [3:0] cfg_val,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase,
    output logic [3:0] sec_left
);

    phase_e     phase_q, phase_d;
    logic [3:0] sec_q, sec_d;
    dir_e       last_dir_q, last_dir_d;
    logic       ped_pending_q, ped_pending_d;
    logic       ped_btn_q, cfg_load_q;
    logic [3:0] tbl_q [4];
    logic [2:0] ns_q, ew_q;
    logic       walk_q;

    logic tick, expire, recover, entry;
    logic ped_rise, cfg_rise;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (entry),
        .tick    (tick)
    );

    assign ped_rise = ped_btn && !ped_btn_q;
    assign cfg_rise = cfg_load && !cfg_load_q;

    always_comb begin
        phase_d    = phase_q;
        last_dir_d = last_dir_q;
        recover    = 1'b0;
        expire     = tick && (sec_q <= 4'd1);

        unique case (phase_q)
            StInit: if (expire) phase_d = StNsG;
            StNsG:  if (expire && (req_ew || ped_pending_q)) phase_d = StNsY;
            StNsY: begin
                if (expire) begin
                    phase_d    = StClr;
                    last_dir_d = DirNs;
                end
            end
            StClr: begin
                if (expire) begin
                    if (ped_pending_q)              phase_d = StPed;
                    else if (last_dir_q == DirNs)   phase_d = StEwG;
                    else                            phase_d = StNsG;
                end
            end
            StEwG:  if (expire && (req_ns || ped_pending_q)) phase_d = StEwY;
            StEwY: begin
                if (expire) begin
                    phase_d    = StClr;
                    last_dir_d = DirEw;
                end
            end
            StPed:  if (expire) phase_d = (last_dir_q == DirNs) ? StEwG : StNsG;
            default: begin
                phase_d = StInit;
                recover = 1'b1;
            end
        endcase

        // A green hold is also an entry: it reloads the (possibly rewritten) green time.
        entry = expire || recover;

        sec_d = sec_q;
        if (entry) begin
            sec_d = load_secs(tbl_q[secs_sel(phase_d)]);
        end else if (tick) begin
            sec_d = sec_q - 4'd1;
        end

        ped_pending_d = ped_pending_q;
        if (entry && (phase_d == StPed)) begin
            ped_pending_d = 1'b0;
        end else if (ped_rise && (phase_q != StPed)) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q          <= StInit;
            sec_q            <= 4'(DEF_ALLRED);
            last_dir_q       <= DirEw;
            ped_pending_q    <= 1'b0;
            ped_btn_q        <= 1'b0;
            cfg_load_q       <= 1'b0;
            ns_q             <= LightRed;
            ew_q             <= LightRed;
            walk_q           <= 1'b0;
            tbl_q[CfgGreen]  <= 4'(DEF_GREEN);
            tbl_q[CfgYellow] <= 4'(DEF_YELLOW);
            tbl_q[CfgAllRed] <= 4'(DEF_ALLRED);
            tbl_q[CfgWalk]   <= 4'(DEF_WALK);
        end else begin
            phase_q       <= phase_d;
            sec_q         <= sec_d;
            last_dir_q    <= last_dir_d;
            ped_pending_q <= ped_pending_d;
            ped_btn_q     <= ped_btn;
            cfg_load_q    <= cfg_load;
            ns_q          <= ns_head(phase_d);
            ew_q          <= ew_head(phase_d);
            walk_q        <= (phase_d == StPed);
            if (cfg_rise) begin
                tbl_q[cfg_sel] <= cfg_val;
            end
        end
    end

    assign phase    = phase_q;
    assign sec_left = sec_q;
    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign ped_walk = walk_q;

endmodule

// File: tb/tb_semaforo_sched.sv
// Self-checking bench for semaforo_sched at CLK_HZ=4: a table of stimulus segments
// feeds a scoreboard queue that is popped and compared one cycle later.
module tb_semaforo_sched;

    localparam int Hz = 4;

    localparam int PInit = 0;
    localparam int PNsG  = 1;
    localparam int PNsY  = 2;
    localparam int PClr  = 3;
    localparam int PEwG  = 4;
    localparam int PEwY  = 5;
    localparam int PPed  = 6;

    logic       clk = 1'b0;
    logic       rst, req_ns, req_ew, ped_btn, cfg_load;
    logic [1:0] cfg_sel;
    logic [3:0] cfg_val;
    logic [2:0] ns_light, ew_light, phase;
    logic       ped_walk;
    logic [3:0] sec_left;

    always #5 clk = ~clk;

    semaforo_sched #(
        .CLK_HZ (Hz)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_ns   (req_ns),
        .req_ew   (req_ew),
        .ped_btn  (ped_btn),
        .cfg_load (cfg_load),
        .cfg_sel  (cfg_sel),
        .cfg_val  (cfg_val),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ped_walk (ped_walk),
        .phase    (phase),
        .sec_left (sec_left)
    );

    // One segment: inputs held for n cycles; the phase stays ph and sec_left counts
    // down from sec, with off cycles of the current second already elapsed.
    typedef struct {
        int r, rns, rew, pb, ld, sel, val;
        int ph, sec, off, n;
    } vec_t;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] sec;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } obs_t;

    vec_t vecs[$];
    obs_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t row(input int r, rns, rew, pb, ld, sel, val, ph, sec, off, n);
        vec_t v;
        v.r = r; v.rns = rns; v.rew = rew; v.pb = pb; v.ld = ld; v.sel = sel; v.val = val;
        v.ph = ph; v.sec = sec; v.off = off; v.n = n;
        return v;
    endfunction

    function automatic obs_t mk(input int ph, input int sec);
        obs_t o;
        o.ph   = ph[2:0];
        o.sec  = sec[3:0];
        o.ns   = 3'b100;
        o.ew   = 3'b100;
        o.walk = (ph == PPed);
        if (ph == PNsG) o.ns = 3'b001;
        if (ph == PNsY) o.ns = 3'b010;
        if (ph == PEwG) o.ew = 3'b001;
        if (ph == PEwY) o.ew = 3'b010;
        return o;
    endfunction

    task automatic check(input int tag);
        obs_t got, want;
        got  = {phase, sec_left, ns_light, ew_light, ped_walk};
        want = exp_q.pop_front();
        total++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL step %0d: got phase=%0d sec_left=%0d ns=%b ew=%b walk=%b, required phase=%0d sec_left=%0d ns=%b ew=%b walk=%b",
                     tag, got.ph, got.sec, got.ns, got.ew, got.walk,
                     want.ph, want.sec, want.ns, want.ew, want.walk);
        end
    endtask

    task automatic step(input int r, rns, rew, pb, ld, sel, val, ph, sec, tag);
        rst      = r[0];
        req_ns   = rns[0];
        req_ew   = rew[0];
        ped_btn  = pb[0];
        cfg_load = ld[0];
        cfg_sel  = sel[1:0];
        cfg_val  = val[3:0];
        exp_q.push_back(mk(ph, sec));
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst = 1'b1; req_ns = 1'b0; req_ew = 1'b0; ped_btn = 1'b0;
        cfg_load = 1'b0; cfg_sel = 2'd0; cfg_val = 4'd0;

        //                r rns rew pb ld sel val  ph     sec off  n
        // Idle: INIT for one second, then NS_G counts down and holds.
        vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, PInit, 1, 0,  1));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, PInit, 1, 1,  3));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, PNsG,  4, 0, 16));
        vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, PNsG,  4, 0,  8));
        // EW demand from reset: NS_G -> NS_Y -> CLR -> EW_G, EW_G holds without NS demand.
        vecs.push_back(row(1, 0, 1, 0, 0, 0, 0, PInit, 1, 0,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PInit, 1, 1,  3));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsG,  4, 0, 16));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsY,  2, 0,  8));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PClr,  1, 0,  4));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PEwG,  4, 0,  4));
        // Ped press in EW_G with NS demand -> EW_Y -> CLR -> PED -> NS_G.
        vecs.push_back(row(0, 1, 0, 1, 0, 0, 0, PEwG,  3, 0,  1));
        vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, PEwG,  3, 1, 11));
        vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, PEwY,  2, 0,  8));
        vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, PClr,  1, 0,  4));
        // Presses on the PED entry cycle and mid-PED must leave nothing pending.
        vecs.push_back(row(0, 1, 0, 1, 0, 0, 0, PPed,  3, 0,  1));
        vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, PPed,  3, 1,  3));
        vecs.push_back(row(0, 1, 0, 1, 0, 0, 0, PPed,  2, 0,  1));
        vecs.push_back(row(0, 1, 0, 0, 0, 0, 0, PPed,  2, 1,  7));
        // Table writes in NS_G: yellow=0 and green=6; running countdown is unaffected.
        vecs.push_back(row(0, 0, 1, 0, 1, 1, 0, PNsG,  4, 0,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 1, 0, PNsG,  4, 1,  1));
        vecs.push_back(row(0, 0, 1, 0, 1, 0, 6, PNsG,  4, 2,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 6, PNsG,  4, 3, 13));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsY,  1, 0,  4));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PClr,  1, 0,  4));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PEwG,  6, 0,  8));
        // Reset mid NS_Y with a pending ped request: restart, no PED afterwards.
        vecs.push_back(row(1, 0, 1, 0, 0, 0, 0, PInit, 1, 0,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PInit, 1, 1,  3));
        vecs.push_back(row(0, 0, 1, 1, 0, 0, 0, PNsG,  4, 0,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsG,  4, 1, 15));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsY,  2, 0,  4));
        vecs.push_back(row(1, 0, 1, 0, 0, 0, 0, PInit, 1, 0,  1));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PInit, 1, 1,  3));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsG,  4, 0, 16));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PNsY,  2, 0,  8));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PClr,  1, 0,  4));
        vecs.push_back(row(0, 0, 1, 0, 0, 0, 0, PEwG,  4, 0,  4));

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n; i++) begin
                step(vecs[k].r, vecs[k].rns, vecs[k].rew, vecs[k].pb, vecs[k].ld,
                     vecs[k].sel, vecs[k].val, vecs[k].ph,
                     vecs[k].sec - (vecs[k].off + i) / Hz, k * 1000 + i);
            end
        end

        // Green write landing on the NS_G entry cycle: entry loads the old 4,
        // the following hold reload picks up the new 2.
        step(1, 0, 0, 0, 0, 0, 0, PInit, 1, 90000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, PInit, 1, 90001 + i);
        step(0, 0, 0, 0, 1, 0, 2, PNsG, 4, 90010);
        for (int i = 1; i < 16; i++) step(0, 0, 0, 0, 0, 0, 2, PNsG, 4 - i / Hz, 90010 + i);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 2, PNsG, 2 - i / Hz, 90100 + i);
        step(0, 0, 0, 0, 0, 0, 2, PNsG, 2, 90200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/semaforo_sched.md
Name: semaforo_sched

Overview:
- Actuated two-approach intersection controller: sequences north-south (NS) and east-west (EW) signal heads plus one pedestrian phase.
- Seconds-based phase timing with a run-time timing table loaded from switches and a key; vehicle sensors drive gap-out/hold.
- Sits between board inputs (sw/KEY) and the light LEDs/HEX decode; display decoding is external.

Parameters:
- CLK_HZ, 50000000, clock cycles per second; benches use 4.
- DEF_GREEN, 4, reset green time in seconds.
- DEF_YELLOW, 2, reset yellow time in seconds.
- DEF_ALLRED, 1, reset all-red clearance in seconds.
- DEF_WALK, 3, reset pedestrian walk time in seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_ns  in  1  NS vehicle-present sensor, level.
- req_ew  in  1  EW vehicle-present sensor, level.
- ped_btn  in  1  pedestrian button, level; rising edge registers a request.
- cfg_load  in  1  config strobe, level; rising edge writes the table.
- cfg_sel  in  2  table entry: 0 green, 1 yellow, 2 all-red, 3 walk.
- cfg_val  in  4  seconds, 0..15.
- ns_light  out  3  {R,Y,G} one-hot.
- ew_light  out  3  {R,Y,G} one-hot.
- ped_walk  out  1  walk lamp.
- phase  out  3  state code.
- sec_left  out  4  seconds remaining in the current phase.
- Interface rule: one clock; reset is synchronous and active-high. Ports are named clk and rst.

Behaviour:
- States and codes: INIT=0, NS_G=1, NS_Y=2, CLR=3, EW_G=4, EW_Y=5, PED=6. Code 7 is unreachable and recovers to INIT on the next cycle.
- Reset (rst=1 at clk edge):
  - Outputs: phase=INIT, ns_light=ew_light=100, ped_walk=0, sec_left=DEF_ALLRED.
  - Internal: prescaler=0, ped_pending=0, last_dir=EW, table=defaults, edge-detect registers=0.
  - Reset mid-phase aborts that phase immediately.
- Light decode from the phase register:
  - NS_G: ns=001. NS_Y: ns=010. EW_G: ew=001. EW_Y: ew=010.
  - Every other head/state combination shows 100.
  - ped_walk=1 only in PED.
- Prescaler:
  - Counts 0..CLK_HZ-1 and emits a 1-cycle tick at CLK_HZ-1.
  - Forced to 0 on every phase entry, so each second is exactly CLK_HZ cycles.
- Phase timing:
  - On entry, sec_left loads the table value; a stored 0 is loaded as 1.
  - On tick with sec_left>1: decrement.
  - On tick with sec_left==1: exit. The new phase is visible on the next cycle, so phase duration = N*CLK_HZ cycles.
- Transitions at expiry:
  - INIT -> NS_G.
  - NS_G -> NS_Y, only if req_ew or ped_pending; otherwise hold (reload green time, stay).
  - EW_G -> EW_Y, only if req_ns or ped_pending; otherwise hold.
  - NS_Y -> CLR with last_dir<=NS. EW_Y -> CLR with last_dir<=EW.
  - CLR -> PED if ped_pending; else EW_G if last_dir==NS; else NS_G.
  - PED -> EW_G if last_dir==NS, else NS_G.
- ped_pending:
  - Set on a ped_btn rising edge, except when the current phase is PED.
  - Cleared on PED entry. A press in the same cycle as PED entry is dropped.
- Config:
  - On a cfg_load rising edge, table[cfg_sel]<=cfg_val.
  - The running sec_left is unaffected. The new value applies at the next entry of that phase, including green-hold reloads.
  - A write coinciding with a phase-entry cycle is not seen by that entry; the old value is loaded.
- Sensors are sampled only at the expiry tick; no latching.

Decomposition:
- Package semaforo_pkg:
  - State codes, cfg_sel indices, light encodings {R,Y,G}.
  - Default times.
  - Direction constants NS/EW.
- Sub-module tick_gen (CLK_HZ): inputs clk, rst, restart; output tick.
- Everything else (FSM, table, edge detectors, decode) lives in semaforo_sched.

Test Plan:
- All tests use CLK_HZ=4.
- Reset, all inputs 0 -> INIT with sec_left=1 for 4 cycles -> NS_G with sec_left 4,3,2,1 each 4 cycles, then reload to 4 and stay NS_G indefinitely; ns_light=001, ew_light=100.
- req_ew=1 held from reset -> NS_G 16 cycles, NS_Y 8 cycles (ns=010), CLR 4 cycles (both 100), then EW_G (ew=001); phase codes 1,2,3,4.
- ped_btn pulse during EW_G with req_ns=1 -> EW_Y -> CLR -> PED for 12 cycles (ped_walk=1, both heads 100) -> NS_G; ped_pending=0 afterwards.
- cfg_sel=1, cfg_val=0, cfg_load pulse during NS_G with req_ew=1 -> the next NS_Y loads sec_left=1 and lasts 4 cycles. cfg_sel=0, cfg_val=6 -> the next green loads 6.
- ped_btn rises on the exact PED-entry cycle -> no extra PED phase afterwards. A press during PED is also ignored.
- rst=1 for one cycle mid NS_Y with ped_pending=1 -> next cycle phase=INIT, lights 100/100, sec_left=1; the sequence restarts with NS_G and no PED phase.
